// File: rtl/mips16_fetch_exec_core_if.sv
// mips16_fetch_exec_core_if: imem write port, register-file operands and fetch/decode/execute outputs
// master (driver side): imem_we/imem_waddr/imem_wdata, rd1/rd2 out; pc, ir, wr, controls, alu_out, zero, overflow, halted in
// slave (core side): the same signals with directions reversed
interface mips16_fetch_exec_core_if #(parameter int IMEM_DEPTH = 64);
  logic imem_we;
  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr;
  logic [15:0] imem_wdata, rd1, rd2, pc, ir, alu_out;
  logic [1:0] wr;
  logic [3:0] alu_control;
  logic reg_dst, alu_src, reg_write, zero, overflow, halted;
  modport master(
    output imem_we, imem_waddr, imem_wdata, rd1, rd2,
    input pc, ir, wr, reg_dst, alu_src, reg_write, alu_control, alu_out, zero, overflow, halted
  );
  modport slave(
    input imem_we, imem_waddr, imem_wdata, rd1, rd2,
    output pc, ir, wr, reg_dst, alu_src, reg_write, alu_control, alu_out, zero, overflow, halted
  );
endinterface

// File: rtl/mips16_fetch_exec_core.sv
// mips16_fetch_exec_core: instruction memory, PC/halt latch, decoder, operand mux and 16-bit ALU
// Ports: clock (PC on falling edge, memory write on rising edge), reset_n (async active-low),
//   bus (slave modport of mips16_fetch_exec_core_if: imem write port, rd1/rd2 in, fetch/decode/ALU outputs).
// Optional macro ALU_OVERFLOW_EN: drives signed overflow for ADD/SUB; otherwise overflow is tied low.
module mips16_fetch_exec_core #(parameter int IMEM_DEPTH = 64) (
  input logic clock,
  input logic reset_n,
  mips16_fetch_exec_core_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  // Memory is not touched by reset; its power-up image is all-ones (halt opcode).
  logic [15:0] mem_q [IMEM_DEPTH] = '{default: 16'hFFFF};
  logic [15:0] pc_q, pc_d, ir, b, y;
  logic [3:0] ctl;
  logic halted_q, halted_d, r_type, i_type, ovf;
  always_ff @(posedge clock)
    if (bus.imem_we) mem_q[bus.imem_waddr] <= bus.imem_wdata;
  // Fetches past the end of memory read as the halt opcode.
  assign ir = (32'(pc_q[15:1]) < IMEM_DEPTH) ? mem_q[pc_q[AW:1]] : 16'hFFFF;
  always_comb begin
    halted_d = halted_q | (ir == 16'hFFFF);
    pc_d = halted_d ? pc_q : pc_q + 16'd2;
  end
  always_ff @(negedge clock or negedge reset_n)
    if (!reset_n) begin
      pc_q <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      halted_q <= halted_d;
    end
  assign r_type = ir[15:12] <= 4'd5;
  assign i_type = ir[15:12] == 4'd6;
  always_comb
    case (ir[15:12])
      4'd1: ctl = 4'b0110;
      4'd2: ctl = 4'b0000;
      4'd3: ctl = 4'b0001;
      4'd4: ctl = 4'b1100;
      4'd5: ctl = 4'b0111;
      default: ctl = 4'b0010;
    endcase
  assign b = i_type ? {{8{ir[7]}}, ir[7:0]} : bus.rd2;
  always_comb
    case (ctl)
      4'b0000: y = bus.rd1 & b;
      4'b0001: y = bus.rd1 | b;
      4'b0010: y = bus.rd1 + b;
      4'b0110: y = bus.rd1 - b;
      4'b0111: y = {15'd0, $signed(bus.rd1) < $signed(b)};
      4'b1100: y = ~(bus.rd1 | b);
      default: y = '0;
    endcase
`ifdef ALU_OVERFLOW_EN
  assign ovf = (ctl == 4'b0010 && bus.rd1[15] == b[15] && y[15] != bus.rd1[15]) ||
               (ctl == 4'b0110 && bus.rd1[15] != b[15] && y[15] != bus.rd1[15]);
`else
  assign ovf = 1'b0;
`endif
  assign bus.pc = pc_q;
  assign bus.halted = halted_q;
  assign bus.ir = ir;
  assign bus.reg_dst = r_type;
  assign bus.alu_src = i_type;
  assign bus.reg_write = (r_type | i_type) & ~halted_q;
  assign bus.wr = r_type ? ir[7:6] : ir[9:8];
  assign bus.alu_control = ctl;
  assign bus.alu_out = y;
  assign bus.zero = y == 16'd0;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_mips16_fetch_exec_core.sv
// tb_mips16_fetch_exec_core: directed vector table plus fetch/halt, reset and end-of-memory sequences
module tb_mips16_fetch_exec_core;
`ifdef ALU_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif
  localparam int NV = 13;
  typedef struct packed {
    logic [15:0] ins, a, b, y;
    logic [1:0] wr;
    logic dst, src, rw;
    logic [3:0] ctl;
    logic z, v;
  } vec_t;
  vec_t vecs [NV];
  logic clock, reset_n;
  int n_vec = 0, n_err = 0;
  mips16_fetch_exec_core_if #(.IMEM_DEPTH(64)) bus();
  mips16_fetch_exec_core #(.IMEM_DEPTH(64)) dut(.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic wr_mem(input int w, input logic [15:0] d);
    @(negedge clock);
    bus.imem_we = 1'b1;
    bus.imem_waddr = 6'(w);
    bus.imem_wdata = d;
    @(posedge clock);
    #1 bus.imem_we = 1'b0;
  endtask
  initial begin
    clock = 1'b0;
    reset_n = 1'b0;
    bus.imem_we = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    bus.rd1 = '0;
    bus.rd2 = '0;
    //            ins       a         b         y         wr    dst   src   rw    ctl      z     v
    vecs[0]  = '{16'h6103, 16'h0005, 16'h0000, 16'h0008, 2'd1, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0};
    vecs[1]  = '{16'h1480, 16'h0007, 16'h0007, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0};
    vecs[2]  = '{16'h5000, 16'hFFFF, 16'h0001, 16'h0001, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0};
    vecs[3]  = '{16'h60FE, 16'h0001, 16'h0000, 16'hFFFF, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0};
    vecs[4]  = '{16'h0000, 16'h7FFF, 16'h0001, 16'h8000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1};
    vecs[5]  = '{16'h2000, 16'hF0F0, 16'hFF00, 16'hF000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{16'h3040, 16'hF0F0, 16'h0F00, 16'hFFF0, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0};
    vecs[7]  = '{16'h40C0, 16'hF0F0, 16'h0F00, 16'h000F, 2'd3, 1'b1, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b0};
    vecs[8]  = '{16'h5000, 16'h0001, 16'hFFFF, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b0};
    vecs[9]  = '{16'h7ABC, 16'h0001, 16'h0002, 16'h0003, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[10] = '{16'h8100, 16'h0005, 16'h0006, 16'h000B, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[11] = '{16'h1000, 16'h8000, 16'h0001, 16'h7FFF, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1};
    vecs[12] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0};
    repeat (2) @(posedge clock);
    #1;
    chk("rst pc", bus.pc, 16'h0000);
    chk("rst halted", 16'(bus.halted), 16'h0000);
    chk("powerup ir", bus.ir, 16'hFFFF);
    // Reset held low pins pc at 0, so each vector is written to word 0 and read straight back.
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      bus.imem_we = 1'b1;
      bus.imem_waddr = '0;
      bus.imem_wdata = vecs[i].ins;
      bus.rd1 = vecs[i].a;
      bus.rd2 = vecs[i].b;
      @(posedge clock);
      #1 bus.imem_we = 1'b0;
      chk($sformatf("v%0d ir", i), bus.ir, vecs[i].ins);
      chk($sformatf("v%0d alu_out", i), bus.alu_out, vecs[i].y);
      chk($sformatf("v%0d wr", i), 16'(bus.wr), 16'(vecs[i].wr));
      chk($sformatf("v%0d reg_dst", i), 16'(bus.reg_dst), 16'(vecs[i].dst));
      chk($sformatf("v%0d alu_src", i), 16'(bus.alu_src), 16'(vecs[i].src));
      chk($sformatf("v%0d reg_write", i), 16'(bus.reg_write), 16'(vecs[i].rw));
      chk($sformatf("v%0d alu_control", i), 16'(bus.alu_control), 16'(vecs[i].ctl));
      chk($sformatf("v%0d zero", i), 16'(bus.zero), 16'(vecs[i].z));
      chk($sformatf("v%0d overflow", i), 16'(bus.overflow), 16'(vecs[i].v & OVF));
    end
    for (int w = 0; w < 3; w++) wr_mem(w, 16'h0000);
    wr_mem(3, 16'hFFFF);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      #1;
      chk($sformatf("fetch pc step %0d", i), bus.pc, 16'(2 * i));
      chk($sformatf("fetch halted step %0d", i), 16'(bus.halted), 16'h0000);
    end
    @(negedge clock);
    #1;
    chk("halt latch", 16'(bus.halted), 16'h0001);
    chk("halt pc", bus.pc, 16'h0006);
    chk("halt reg_write", 16'(bus.reg_write), 16'h0000);
    wr_mem(3, 16'h0000);
    chk("write visible ir", bus.ir, 16'h0000);
    chk("halted reg_write forced", 16'(bus.reg_write), 16'h0000);
    chk("halted pc after write", bus.pc, 16'h0006);
    repeat (2) begin
      @(negedge clock);
      #1;
      chk("halted pc holds", bus.pc, 16'h0006);
      chk("halted stays", 16'(bus.halted), 16'h0001);
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst pc", bus.pc, 16'h0000);
    chk("async rst halted", 16'(bus.halted), 16'h0000);
    for (int w = 0; w < 64; w++) wr_mem(w, 16'h0000);
    reset_n = 1'b1;
    for (int c = 0; c < 200 && !bus.halted; c++) begin
      @(negedge clock);
      #1;
    end
    chk("end-of-mem halted", 16'(bus.halted), 16'h0001);
    chk("end-of-mem pc", bus.pc, 16'h0080);
    chk("end-of-mem ir", bus.ir, 16'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
